bcd_digit_entry: RTL and testbench

- Operator input front end for the RSA board demo; the input-side counterpart of the seven-segment output path.
- Takes three raw push-buttons (up, down, enter) and synchronizes and debounces them.
- Lets the operator edit a two-digit decimal value (tens, then ones) and commits it as a 7-bit binary number with a one-cycle valid strobe.
- The currently edited digit and its position are exported so the seven-segment path can echo them.

---
 rtl/bcd_digit_entry.sv | 131 +++++++++++++
 tb/tb_bcd_digit_entry.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_entry.sv
// Push-button front end: syncs and debounces up/down/enter and edits a two-digit decimal value.
// Commits tens*10+ones as a 7-bit binary value with a one-cycle valid strobe.
module bcd_digit_entry #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned DB_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  output logic [3:0] digit,
  output logic       digit_pos,
  output logic [6:0] value,
  output logic       value_valid
);

  typedef enum logic [0:0] {STens, SOnes} state_e;

  localparam logic [DB_W-1:0] CntMax = DB_W'(DB_CYCLES - 1);

  // Bit order for all per-button vectors: {enter, down, up}
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q, deb_prev_q;
  logic [2:0]      press;
  logic [DB_W-1:0] cnt_q [3];

  assign raw   = {btn_enter, btn_down, btn_up};
  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [6:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       up, down, enter;

  assign up    = press[0];
  assign down  = press[1];
  assign enter = press[2];

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    value_d = value_q;
    valid_d = 1'b0;
    unique case (state_q)
      STens: begin
        // enter wins over any up/down pulse in the same cycle
        if (enter) begin
          state_d = SOnes;
          ones_d  = 4'd0;
        end else if (up && !down) begin
          tens_d = bcd_inc(tens_q);
        end else if (down && !up) begin
          tens_d = bcd_dec(tens_q);
        end
      end
      SOnes: begin
        if (enter) begin
          value_d = {3'b000, tens_q} * 7'd10 + {3'b000, ones_q};
          valid_d = 1'b1;
          state_d = STens;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end else if (up && !down) begin
          ones_d = bcd_inc(ones_q);
        end else if (down && !up) begin
          ones_d = bcd_dec(ones_q);
        end
      end
      default: state_d = STens;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STens;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      value_q <= 7'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign digit       = (state_q == STens) ? tens_q : ones_q;
  assign digit_pos   = (state_q == STens);
  assign value       = value_q;
  assign value_valid = valid_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed timing/reset sequences, a vector table, and random
// button actions checked against a digit-level model.
module tb_bcd_digit_entry;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_enter = 1'b0;
  logic [3:0] digit;
  logic       digit_pos;
  logic [6:0] value;
  logic       value_valid;

  int n_pass = 0;
  int n_total = 0;
  int vcount = 0;
  int vdouble = 0;
  logic vprev = 1'b0;

  always #5 clk = ~clk;

  bcd_digit_entry #(
    .DB_CYCLES(4),
    .DB_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_enter  (btn_enter),
    .digit      (digit),
    .digit_pos  (digit_pos),
    .value      (value),
    .value_valid(value_valid)
  );

  // Strobe monitor: counts value_valid pulses and flags any two-cycle-wide strobe
  always @(negedge clk) begin
    if (value_valid) vcount <= vcount + 1;
    if (value_valid && vprev) vdouble <= vdouble + 1;
    vprev <= value_valid;
  end

  typedef struct {
    logic u;
    logic d;
    logic e;
    int   dig;
    int   pos;
    int   val;
    int   vc;
  } vec_t;

  vec_t vecs[28];

  // Digit-level reference model
  int m_tens, m_ones, m_value, m_pulses;
  bit m_in_ones;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic u, input logic d, input logic e);
    btn_up = u;
    btn_down = d;
    btn_enter = e;
    tick(8);
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_enter = 1'b0;
    tick(12);
  endtask

  task automatic model_apply(input logic u, input logic d, input logic e);
    if (e) begin
      if (!m_in_ones) begin
        m_in_ones = 1'b1;
        m_ones = 0;
      end else begin
        m_value = m_tens * 10 + m_ones;
        m_pulses++;
        m_in_ones = 1'b0;
        m_tens = 0;
        m_ones = 0;
      end
    end else if (u && !d) begin
      if (m_in_ones) m_ones = (m_ones + 1) % 10;
      else m_tens = (m_tens + 1) % 10;
    end else if (d && !u) begin
      if (m_in_ones) m_ones = (m_ones + 9) % 10;
      else m_tens = (m_tens + 9) % 10;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, (i + 1) % 10, 1, 0, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 9, 1, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0};
    for (int i = 12; i < 16; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, i - 11, 1, 0, 0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 0, 1, 42, 1};
    for (int i = 20; i < 23; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, i - 19, 1, 42, 1};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 0, 0, 42, 1};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 0, 0, 42, 1};
    vecs[25] = '{1'b1, 1'b0, 1'b0, 1, 0, 42, 1};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 1, 0, 42, 1};
    vecs[27] = '{1'b0, 1'b0, 1'b1, 0, 1, 31, 2};

    // Reset and idle
    tick(3);
    check("rst_digit", digit, 0);
    check("rst_pos", digit_pos, 1);
    check("rst_value", value, 0);
    check("rst_valid", value_valid, 0);
    rst_n = 1'b1;
    tick(100);
    check("idle_digit", digit, 0);
    check("idle_pos", digit_pos, 1);
    check("idle_value", value, 0);
    check("idle_vcount", vcount, 0);

    // 3-cycle glitch must be filtered
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(20);
    check("glitch_digit", digit, 0);

    // Clean press: update lands exactly 7 cycles after the raw edge
    btn_up = 1'b1;
    tick(6);
    check("lat_cycle6", digit, 0);
    tick(1);
    check("lat_cycle7", digit, 1);
    tick(3);
    btn_up = 1'b0;
    tick(20);
    check("lat_single_inc", digit, 1);

    do_reset();
    foreach (vecs[i]) begin
      press(vecs[i].u, vecs[i].d, vecs[i].e);
      check($sformatf("vec%0d_digit", i), digit, vecs[i].dig);
      check($sformatf("vec%0d_pos", i), digit_pos, vecs[i].pos);
      check($sformatf("vec%0d_value", i), value, vecs[i].val);
      check($sformatf("vec%0d_vcount", i), vcount, vecs[i].vc);
    end

    // Reset mid-entry discards partial entry
    repeat (7) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    repeat (5) press(1'b1, 1'b0, 1'b0);
    check("mid_digit_pre", digit, 5);
    check("mid_pos_pre", digit_pos, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_digit", digit, 0);
    check("mid_rst_pos", digit_pos, 1);
    check("mid_rst_value", value, 0);
    check("mid_rst_valid", value_valid, 0);
    #1 rst_n = 1'b1;
    tick(2);
    press(1'b0, 1'b0, 1'b1);
    repeat (9) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("post_rst_value", value, 9);
    check("post_rst_vcount", vcount, 3);

    // Random actions against the model
    do_reset();
    m_tens = 0;
    m_ones = 0;
    m_value = 0;
    m_pulses = 3;
    m_in_ones = 1'b0;
    for (int k = 0; k < 80; k++) begin
      int combo;
      if ($urandom_range(0, 3) == 0) begin
        combo = $urandom_range(1, 7);
        btn_up = combo[0];
        btn_down = combo[1];
        btn_enter = combo[2];
        tick($urandom_range(1, 3));
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_enter = 1'b0;
        tick(10);
      end
      combo = $urandom_range(0, 7);
      press(combo[0], combo[1], combo[2]);
      model_apply(combo[0], combo[1], combo[2]);
      check($sformatf("rnd%0d_digit", k), digit, m_in_ones ? m_ones : m_tens);
      check($sformatf("rnd%0d_pos", k), digit_pos, m_in_ones ? 0 : 1);
      check($sformatf("rnd%0d_value", k), value, m_value);
      check($sformatf("rnd%0d_vcount", k), vcount, m_pulses);
    end

    check("valid_single_cycle", vdouble, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
